// File: rtl/oh_parchk.sv
// Parity checker in front of a 2-entry in-order skid buffer.
// Every word accepted from the link is tagged with its parity result, passed
// downstream in order, and counted in a saturating error counter and a sticky flag.
module oh_parchk #(
  parameter int N   = 8,
  parameter int CW  = 8,
  parameter int ODD = 0
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          clear,
  input  logic          in_valid,
  input  logic [N-1:0]  in_data,
  input  logic          in_parity,
  output logic          in_ready,
  output logic          out_valid,
  output logic [N-1:0]  out_data,
  output logic          out_err,
  input  logic          out_ready,
  output logic [CW-1:0] err_count,
  output logic          err_sticky
);

  typedef enum logic [1:0] {EMPTY = 2'd0, HALF = 2'd1, FULL = 2'd2} state_e;

  state_e         state_q, state_d;
  logic [N-1:0]   head_data_q, head_data_d, tail_data_q, tail_data_d;
  logic           head_err_q, head_err_d, tail_err_q, tail_err_d;
  logic           rdy_q, rdy_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           sticky_q, sticky_d;

  logic push, pop, in_err;
  logic odd_c;

  assign odd_c  = (ODD != 0);
  // Mismatch between recomputed and received parity for the word on the link.
  assign in_err = (^in_data) ^ odd_c ^ in_parity;

  // rdy_q is zero for the first cycle after reset, so nothing is pushed on
  // that edge even though the buffer is EMPTY.
  assign push = in_valid & rdy_q;
  assign pop  = (state_q != EMPTY) & out_ready;

  assign in_ready   = rdy_q;
  assign out_valid  = (state_q != EMPTY);
  assign out_data   = head_data_q;
  assign out_err    = head_err_q;
  assign err_count  = cnt_q;
  assign err_sticky = sticky_q;

  // State, buffer entries, ready and error statistics.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q     <= EMPTY;
      head_data_q <= '0;
      head_err_q  <= 1'b0;
      tail_data_q <= '0;
      tail_err_q  <= 1'b0;
      rdy_q       <= 1'b0;
      cnt_q       <= '0;
      sticky_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      head_data_q <= head_data_d;
      head_err_q  <= head_err_d;
      tail_data_q <= tail_data_d;
      tail_err_q  <= tail_err_d;
      rdy_q       <= rdy_d;
      cnt_q       <= cnt_d;
      sticky_q    <= sticky_d;
    end
  end

  // Next-state: occupancy FSM moving words head <- tail <- link.
  always_comb begin
    state_d     = state_q;
    head_data_d = head_data_q;
    head_err_d  = head_err_q;
    tail_data_d = tail_data_q;
    tail_err_d  = tail_err_q;
    unique case (state_q)
      EMPTY: begin
        if (push) begin
          head_data_d = in_data;
          head_err_d  = in_err;
          state_d     = HALF;
        end
      end
      HALF: begin
        if (push && pop) begin
          // Head leaves and the incoming word takes its place.
          head_data_d = in_data;
          head_err_d  = in_err;
        end else if (push) begin
          tail_data_d = in_data;
          tail_err_d  = in_err;
          state_d     = FULL;
        end else if (pop) begin
          state_d     = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          head_data_d = tail_data_q;
          head_err_d  = tail_err_q;
          state_d     = HALF;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Registered ready looks ahead at next occupancy so it never depends
    // combinationally on out_ready or in_valid.
    rdy_d = (state_d != FULL);
  end

  // Error statistics; clear wins over a coincident erroneous push.
  always_comb begin
    cnt_d    = cnt_q;
    sticky_d = sticky_q;
    if (clear) begin
      cnt_d    = '0;
      sticky_d = 1'b0;
    end else if (push && in_err) begin
      if (cnt_q != {CW{1'b1}}) cnt_d = cnt_q + CW'(1);
      sticky_d = 1'b1;
    end
  end

endmodule

// File: tb/tb_oh_parchk.sv
// Bench for oh_parchk: two instances share one stimulus stream, an even-parity
// 8-bit counter build and an odd-parity 2-bit counter build. Accepted words are
// queued with their expected parity result; the output side is checked against
// the queue head, and error counts against a simple per-instance tally.
module tb_oh_parchk;

  logic       clk = 1'b0;
  logic       nreset = 1'b0;
  logic       clear = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_parity = 1'b0;
  logic       out_ready = 1'b1;

  logic       in_ready, out_valid, out_err, err_sticky;
  logic [7:0] out_data, err_count;
  logic       in_ready2, out_valid2, out_err2, err_sticky2;
  logic [7:0] out_data2;
  logic [1:0] err_count2;

  int checks = 0;
  int errors = 0;

  oh_parchk #(.N(8), .CW(8), .ODD(0)) dut (
    .clk(clk), .nreset(nreset), .clear(clear),
    .in_valid(in_valid), .in_data(in_data), .in_parity(in_parity),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_err(out_err), .out_ready(out_ready),
    .err_count(err_count), .err_sticky(err_sticky)
  );

  oh_parchk #(.N(8), .CW(2), .ODD(1)) dut2 (
    .clk(clk), .nreset(nreset), .clear(clear),
    .in_valid(in_valid), .in_data(in_data), .in_parity(in_parity),
    .in_ready(in_ready2), .out_valid(out_valid2), .out_data(out_data2),
    .out_err(out_err2), .out_ready(out_ready),
    .err_count(err_count2), .err_sticky(err_sticky2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Each entry: {data, even-sense error}. Odd-sense error is its inverse.
  logic [8:0] q[$];
  int  cnt0 = 0, cnt1 = 0;
  bit  st0 = 0, st1 = 0;
  bit  armed = 0;

  always @(negedge nreset) begin
    q.delete();
    cnt0 = 0; cnt1 = 0; st0 = 0; st1 = 0; armed = 0;
  end

  // Transfer monitor: record pushes, compare pops.
  always @(posedge clk) begin
    if (nreset) begin
      logic e;
      logic [8:0] h;
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("pop_from_empty", 1, 0);
        end else begin
          h = q.pop_front();
          chk("pop_data", out_data, h[8:1]);
          chk("pop_err", out_err, h[0]);
          chk("pop_data_odd", out_data2, h[8:1]);
          chk("pop_err_odd", out_err2, !h[0]);
        end
      end
      e = (^in_data) ^ in_parity;
      if (in_valid && in_ready) q.push_back({in_data, e});
      if (clear) begin
        cnt0 = 0; cnt1 = 0; st0 = 0; st1 = 0;
      end else if (in_valid && in_ready) begin
        if (e)  begin cnt0 = (cnt0 < 255) ? cnt0 + 1 : 255; st0 = 1; end
        if (!e) begin cnt1 = (cnt1 < 3)   ? cnt1 + 1 : 3;   st1 = 1; end
      end
      armed = 1;
    end
  end

  // Per-cycle state monitor away from the active edge.
  always @(negedge clk) begin
    if (nreset) begin
      chk("out_valid", out_valid, q.size() != 0);
      chk("in_ready", in_ready, armed && q.size() < 2);
      chk("out_valid_odd", out_valid2, q.size() != 0);
      chk("in_ready_odd", in_ready2, armed && q.size() < 2);
      if (q.size() != 0) begin
        chk("head_data", out_data, q[0][8:1]);
        chk("head_err", out_err, q[0][0]);
        chk("head_err_odd", out_err2, !q[0][0]);
      end
      chk("err_count", err_count, cnt0);
      chk("err_sticky", err_sticky, st0);
      chk("err_count_odd", err_count2, cnt1);
      chk("err_sticky_odd", err_sticky2, st1);
    end
  end

  // ---------------- stimulus ----------------
  // Called at a negedge; returns at the negedge after the word is accepted.
  task automatic send(input logic [7:0] d, input logic p);
    bit ok;
    int n;
    in_valid = 1'b1; in_data = d; in_parity = p; n = 0;
    do begin
      ok = in_ready;
      @(posedge clk);
      n++;
    end while (!ok && n < 50);
    if (!ok) chk("send_timeout", 0, 1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  initial begin
    int sent, issued, inj, cyc;
    bit cur_bad, rdy_prev;
    logic [7:0] rd;

    // Reset values while held in reset.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_err", out_err, 0);
    chk("rst_err_count", err_count, 0);
    chk("rst_err_sticky", err_sticky, 0);

    nreset = 1'b1;
    chk("rel_in_ready_low", in_ready, 0);
    @(negedge clk);
    chk("rel_in_ready_high", in_ready, 1);

    // Even-parity basics, one-cycle latency.
    send(8'hA5, 1'b0);
    chk("a5_valid", out_valid, 1);
    chk("a5_data", out_data, 8'hA5);
    chk("a5_err", out_err, 0);
    chk("a5_err_odd", out_err2, 1);
    send(8'h01, 1'b0);
    chk("01_err", out_err, 1);
    @(negedge clk);
    chk("01_count", err_count, 1);
    chk("01_sticky", err_sticky, 1);

    // Odd-parity sense on the second instance.
    send(8'h00, 1'b1);
    chk("odd_ok", out_err2, 0);
    send(8'h00, 1'b0);
    chk("odd_bad", out_err2, 1);

    // Saturating 2-bit counter, then clear against an erroneous push.
    pulse_clear();
    chk("clr_count_odd", err_count2, 0);
    for (int i = 0; i < 5; i++) begin
      send(8'h00, 1'b0);
      rd = (i < 3) ? 8'(i + 1) : 8'd3;
      chk("sat_count_odd", err_count2, rd);
    end
    clear = 1'b1;
    send(8'h00, 1'b0);
    clear = 1'b0;
    chk("clr_push_count_odd", err_count2, 0);
    chk("clr_push_sticky_odd", err_sticky2, 0);
    chk("clr_push_count", err_count, 0);
    @(negedge clk);

    // Backpressure: fill, hold a third word, then release.
    out_ready = 1'b0;
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    chk("bp_in_ready", in_ready, 0);
    in_valid = 1'b1; in_data = 8'h33; in_parity = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("bp_hold_ready", in_ready, 0);
      chk("bp_hold_data", out_data, 8'h11);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_second", out_data, 8'h22);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_third", out_data, 8'h33);
    repeat (2) @(negedge clk);

    // Random streaming.
    pulse_clear();
    sent = 0; issued = 0; inj = 0; cyc = 0; rdy_prev = 0; cur_bad = 0;
    while ((sent < 100 || q.size() != 0) && cyc < 5000) begin
      if (in_valid && rdy_prev) begin
        sent++;
        inj += int'(cur_bad);
        in_valid = 1'b0;
      end
      if (!in_valid && issued < 100 && ($urandom % 4) != 0) begin
        rd = 8'($urandom);
        cur_bad = (($urandom % 4) == 0);
        in_data = rd;
        in_parity = (^rd) ^ cur_bad;
        in_valid = 1'b1;
        issued++;
      end
      out_ready = (($urandom % 3) != 0);
      rdy_prev = in_ready;
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("rand_words_drained", sent, 100);
    chk("rand_err_count", err_count, inj);
    chk("rand_err_sticky", err_sticky, inj != 0);
    @(negedge clk);

    // Reset with buffer FULL.
    out_ready = 1'b0;
    send(8'hAA, 1'b1);
    send(8'hBB, 1'b1);
    chk("full_in_ready", in_ready, 0);
    #2 nreset = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    chk("mid_rst_err_count", err_count, 0);
    chk("mid_rst_out_data", out_data, 0);
    chk("mid_rst_sticky", err_sticky, 0);
    @(negedge clk);
    out_ready = 1'b1;
    nreset = 1'b1;
    chk("post_rst_in_ready_low", in_ready, 0);
    @(negedge clk);
    chk("post_rst_in_ready_high", in_ready, 1);
    chk("post_rst_err_count", err_count, 0);
    chk("post_rst_out_valid", out_valid, 0);
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
